udp_parser: RTL and testbench
=============================

// Module: udp_parser
// PURPOSE
// Stage directly after ip_parser. Consumes the IPv4 payload byte stream, which is
// already version/protocol/address/checksum filtered. Parses the 8-byte UDP header
// and filters on destination port. Strips the header and any Ethernet padding,
// then forwards exactly (udp_len-8) payload bytes with eof/err framing to the application.
// PARAMETERS
// UDP_PORT  16'd5000  accepted destination port; 16'd0 = accept any port
// PORTS
// clk            in   1   clock
// rst_n          in   1   asynchronous active-low reset
// in_data        in   8   payload byte from ip_parser (byte_t)
// in_valid       in   1   in_data valid this cycle
// in_eof         in   1   frame end; qualifies in_valid or stands alone
// in_err         in   1   frame error; with in_valid&in_eof => byte invalid; alone => header reject
// out_data       out  8   UDP payload byte (byte_t)
// out_valid      out  1   out_data valid
// out_eof        out  1   last payload byte / end-of-datagram strobe (may assert with out_valid=0)
// out_err        out  1   datagram errored; discard all bytes since previous out_eof
// hdr_valid      out  1   1-cycle strobe: header accepted; sideband fields below are stable
// udp_src_port   out  16  source port of current datagram
// udp_dst_port   out  16  destination port of current datagram
// udp_len        out  16  UDP length field (header + payload)
// BEHAVIOUR
// - Reset: all outputs 0; state HEADER; hdr_cnt=0; hold register empty.
// - All outputs are registered. out_* asserts 1 clk after the in_valid cycle that causes it.
//   Exception: the held last byte (see PAD). out_valid/out_eof/out_err/hdr_valid default 0 each cycle.
// - HEADER: bytes 0-1 src port, 2-3 dst port, 4-5 length L, 6-7 checksum.
//   Big-endian byte order. Checksum is latched only; it is not verified.
//   On byte 7 (hdr_cnt==7):
//   . dst!=UDP_PORT (UDP_PORT!=0), or L<8 -> out_err=1; go to FLUSH.
//     If in_eof is also set this cycle, go to HEADER instead.
//   . in_eof&in_err -> out_err=1; go to HEADER.
//   . Else hdr_valid=1 and rem=L-8 (16-bit):
//     rem==0 & in_eof -> out_eof=1, out_valid=0, out_err=0; go to HEADER.
//     rem==0 -> go to PAD.
//     rem>0 & in_eof -> out_err=1; go to HEADER (truncated).
//     Otherwise go to PAYLOAD.
//   . in_eof on bytes 0-6 -> out_err=1; go to HEADER, hdr_cnt=0 (runt).
// - PAYLOAD, per in_valid:
//   . in_eof&in_err -> out_valid=out_eof=out_err=1, out_data don't-care; go to HEADER.
//   . rem==1 & in_eof -> forward byte with out_eof=1, out_err=0; go to HEADER.
//   . rem==1 & !in_eof -> store byte in hold register; go to PAD.
//   . rem>1 & in_eof -> forward byte with out_eof=1, out_err=1; go to HEADER (truncated).
//   . rem>1 -> forward byte; rem--.
// - PAD: discard padding bytes until in_eof. On the in_eof cycle:
//   . If hold is full: out_valid=1, out_data=held byte, out_eof=1, out_err=in_err.
//   . If hold is empty (L==8): out_valid=0, out_eof=1, out_err=in_err.
//   Then go to HEADER.
// - FLUSH: discard bytes until in_eof; then go to HEADER. No outputs.
// - Standalone in_err (in_valid=0), any state: go to HEADER, hdr_cnt=0, clear hold.
//   From PAYLOAD/PAD: out_eof=1, out_err=1, out_valid=0.
//   From HEADER/FLUSH: no output.
// - Entering HEADER always clears hdr_cnt and hold. Sideband outputs hold their value
//   until the next hdr_valid.
// - Widths: rem is 16 bits; L>=8 is guaranteed before the subtract; no wrap.
//   Back-to-back frames need no idle cycle.
// - Mid-frame rst_n: immediate return to reset values. The next frame parses cleanly
//   from its first byte.
// TESTING
// 1. Port 5000, L=12, payload DE AD BE EF, eof on EF -> 4 out_valid; out_eof on EF;
//    hdr_valid once; udp_len=12.
// 2. Same datagram plus 6 pad bytes, eof on last pad -> EF out with out_eof when eof
//    arrives; pads never output.
// 3. Same as 2, but eof carries in_err -> EF out with out_eof=1, out_err=1.
// 4. dst port 5001 with UDP_PORT=5000 -> out_err pulse, no hdr_valid, no payload.
//    Next frame (port 5000) passes.
// 5. L=20, eof after 5 payload bytes -> 5th byte has out_eof=1, out_err=1.
//    L=6 -> out_err, FLUSH.
// 6. L=8 with eof on byte 7 -> hdr_valid=1, out_eof=1, out_valid=0.
//    Standalone in_err in PAYLOAD -> out_eof=out_err=1.

Source files
------------

// File: rtl/udp_parser.sv
// rtl/udp_parser.sv - UDP header parser, destination-port filter and payload forwarder
// Sits behind ip_parser; strips the 8-byte UDP header and Ethernet padding.
module udp_parser #(
  parameter logic [15:0] UDP_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_eof,
  input  logic        in_err,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_eof,
  output logic        out_err,
  output logic        hdr_valid,
  output logic [15:0] udp_src_port,
  output logic [15:0] udp_dst_port,
  output logic [15:0] udp_len
);

  typedef enum logic [1:0] {HEADER, PAYLOAD, PAD, FLUSH} state_t;

  state_t      state, state_d;
  logic [2:0]  hdr_cnt, hdr_cnt_d;
  logic [15:0] rem, rem_d;
  logic        hold_full, hold_full_d;
  logic [7:0]  hold_data, hold_data_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [7:0]  data_d;
  logic        valid_d, eof_d, err_d, hv_d;
  logic        port_bad, len_bad;
  logic [15:0] rem_calc;

  // dst and length are complete by byte 5, so the byte-7 decision can use the registers
  assign port_bad = (UDP_PORT != 16'd0) && (dst_q != UDP_PORT);
  assign len_bad  = len_q < 16'd8;
  assign rem_calc = len_q - 16'd8;

  always_comb begin
    state_d     = state;
    hdr_cnt_d   = hdr_cnt;
    rem_d       = rem;
    hold_full_d = hold_full;
    hold_data_d = hold_data;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    data_d      = out_data;
    valid_d     = 1'b0;
    eof_d       = 1'b0;
    err_d       = 1'b0;
    hv_d        = 1'b0;

    if (!in_valid && in_err) begin
      state_d = HEADER;
      if (state == PAYLOAD || state == PAD) begin
        eof_d = 1'b1;
        err_d = 1'b1;
      end
    end else begin
      case (state)
        HEADER: begin
          if (in_valid) begin
            case (hdr_cnt)
              3'd0: src_d[15:8] = in_data;
              3'd1: src_d[7:0]  = in_data;
              3'd2: dst_d[15:8] = in_data;
              3'd3: dst_d[7:0]  = in_data;
              3'd4: len_d[15:8] = in_data;
              3'd5: len_d[7:0]  = in_data;
              default: ;  // checksum bytes are not verified
            endcase
            if (hdr_cnt == 3'd7) begin
              hdr_cnt_d = 3'd0;
              if (port_bad || len_bad) begin
                err_d   = 1'b1;
                state_d = in_eof ? HEADER : FLUSH;
              end else if (in_eof && in_err) begin
                err_d = 1'b1;
              end else begin
                hv_d  = 1'b1;
                rem_d = rem_calc;
                if (rem_calc == 16'd0) begin
                  if (in_eof) eof_d = 1'b1;
                  else        state_d = PAD;
                end else if (in_eof) begin
                  err_d = 1'b1;
                end else begin
                  state_d = PAYLOAD;
                end
              end
            end else if (in_eof) begin
              err_d     = 1'b1;
              hdr_cnt_d = 3'd0;
            end else begin
              hdr_cnt_d = hdr_cnt + 3'd1;
            end
          end else if (in_eof && hdr_cnt != 3'd0) begin
            err_d     = 1'b1;
            hdr_cnt_d = 3'd0;
          end
        end
        PAYLOAD: begin
          if (in_valid) begin
            data_d = in_data;
            if (in_eof && in_err) begin
              valid_d = 1'b1;
              eof_d   = 1'b1;
              err_d   = 1'b1;
              state_d = HEADER;
            end else if (rem == 16'd1) begin
              if (in_eof) begin
                valid_d = 1'b1;
                eof_d   = 1'b1;
                state_d = HEADER;
              end else begin
                // last byte waits for in_eof so a late frame error can still mark it
                data_d      = out_data;
                hold_data_d = in_data;
                hold_full_d = 1'b1;
                state_d     = PAD;
              end
            end else if (in_eof) begin
              valid_d = 1'b1;
              eof_d   = 1'b1;
              err_d   = 1'b1;
              state_d = HEADER;
            end else begin
              valid_d = 1'b1;
              rem_d   = rem - 16'd1;
            end
          end else if (in_eof) begin
            eof_d   = 1'b1;
            err_d   = 1'b1;
            state_d = HEADER;
          end
        end
        PAD: begin
          if (in_eof) begin
            valid_d = hold_full;
            if (hold_full) data_d = hold_data;
            eof_d   = 1'b1;
            err_d   = in_err;
            state_d = HEADER;
          end
        end
        FLUSH: begin
          if (in_eof) state_d = HEADER;
        end
        default: state_d = HEADER;
      endcase
    end

    if (state_d == HEADER && state != HEADER) begin
      hdr_cnt_d   = 3'd0;
      hold_full_d = 1'b0;
    end
    if (!in_valid && in_err) begin
      hdr_cnt_d   = 3'd0;
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HEADER;
      hdr_cnt      <= 3'd0;
      rem          <= 16'd0;
      hold_full    <= 1'b0;
      hold_data    <= 8'd0;
      src_q        <= 16'd0;
      dst_q        <= 16'd0;
      len_q        <= 16'd0;
      out_data     <= 8'd0;
      out_valid    <= 1'b0;
      out_eof      <= 1'b0;
      out_err      <= 1'b0;
      hdr_valid    <= 1'b0;
      udp_src_port <= 16'd0;
      udp_dst_port <= 16'd0;
      udp_len      <= 16'd0;
    end else begin
      state     <= state_d;
      hdr_cnt   <= hdr_cnt_d;
      rem       <= rem_d;
      hold_full <= hold_full_d;
      hold_data <= hold_data_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_eof   <= eof_d;
      out_err   <= err_d;
      hdr_valid <= hv_d;
      if (hv_d) begin
        udp_src_port <= src_q;
        udp_dst_port <= dst_q;
        udp_len      <= len_q;
      end
    end
  end

endmodule

// File: tb/tb_udp_parser.sv
// tb/tb_udp_parser.sv - directed self-checking bench for udp_parser
module tb_udp_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0, in_eof = 1'b0, in_err = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_eof, out_err, hdr_valid;
  logic [15:0] udp_src_port, udp_dst_port, udp_len;

  int total = 0;
  int bad = 0;

  logic [9:0] outq[$];
  logic [9:0] exq[$];
  int hv_cnt = 0, lone_eof = 0, lone_err = 0;

  udp_parser #(.UDP_PORT(16'd5000)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_eof(in_eof), .in_err(in_err),
    .out_data(out_data), .out_valid(out_valid), .out_eof(out_eof), .out_err(out_err),
    .hdr_valid(hdr_valid), .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port),
    .udp_len(udp_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) outq.push_back({out_eof, out_err, out_data});
    else begin
      if (out_eof) lone_eof = lone_eof + 1;
      if (out_err) lone_err = lone_err + 1;
    end
    if (hdr_valid) hv_cnt = hv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    outq.delete(); exq.delete();
    hv_cnt = 0; lone_eof = 0; lone_err = 0;
  endtask

  task automatic tx(input logic [7:0] d, input logic e, input logic r);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_eof = e; in_err = r;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0; in_eof = 1'b0; in_err = 1'b0; in_data = 8'd0;
    repeat (n) @(posedge clk);
  endtask

  task automatic hdr(input logic [15:0] dst, input logic [15:0] len, input logic e);
    tx(8'h12, 0, 0); tx(8'h34, 0, 0);
    tx(dst[15:8], 0, 0); tx(dst[7:0], 0, 0);
    tx(len[15:8], 0, 0); tx(len[7:0], 0, 0);
    tx(8'hAB, 0, 0); tx(8'hCD, e, 0);
  endtask

  task automatic cmp_out(input string tag);
    chk({tag, ".count"}, outq.size(), exq.size());
    for (int i = 0; i < exq.size(); i++)
      chk($sformatf("%s.byte%0d", tag, i), (i < outq.size()) ? outq[i] : 10'h3ff, exq[i]);
  endtask

  task automatic frame1();
    hdr(16'd5000, 16'd12, 0);
    tx(8'hDE, 0, 0); tx(8'hAD, 0, 0); tx(8'hBE, 0, 0); tx(8'hEF, 1, 0);
    idle(3);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", out_valid, 0); chk("rst.eof", out_eof, 0); chk("rst.err", out_err, 0);
    chk("rst.hv", hdr_valid, 0); chk("rst.len", udp_len, 0); chk("rst.dst", udp_dst_port, 0);
    rst_n = 1'b1;
    idle(1);

    // 1: exact-length datagram
    clr(); frame1();
    exq = '{10'h0DE, 10'h0AD, 10'h0BE, 10'h2EF};
    cmp_out("t1"); chk("t1.hv", hv_cnt, 1); chk("t1.len", udp_len, 12);
    chk("t1.src", udp_src_port, 16'h1234); chk("t1.dst", udp_dst_port, 16'd5000);
    chk("t1.lone_err", lone_err, 0);

    // 2: padded datagram; last byte held until eof
    clr(); hdr(16'd5000, 16'd12, 0);
    tx(8'hDE, 0, 0); tx(8'hAD, 0, 0); tx(8'hBE, 0, 0); tx(8'hEF, 0, 0);
    tx(8'h00, 0, 0); tx(8'h00, 0, 0);
    chk("t2.held", outq.size(), 3);
    tx(8'h00, 0, 0); tx(8'h00, 0, 0); tx(8'h00, 0, 0); tx(8'h00, 1, 0);
    idle(3);
    exq = '{10'h0DE, 10'h0AD, 10'h0BE, 10'h2EF};
    cmp_out("t2"); chk("t2.lone_eof", lone_eof, 0);

    // 3: padded datagram, error on eof
    clr(); hdr(16'd5000, 16'd12, 0);
    tx(8'hDE, 0, 0); tx(8'hAD, 0, 0); tx(8'hBE, 0, 0); tx(8'hEF, 0, 0);
    repeat (5) tx(8'h00, 0, 0);
    tx(8'h00, 1, 1);
    idle(3);
    exq = '{10'h0DE, 10'h0AD, 10'h0BE, 10'h3EF};
    cmp_out("t3");

    // 4: wrong port rejected, next frame passes
    clr(); hdr(16'd5001, 16'd12, 0);
    tx(8'hDE, 0, 0); tx(8'hAD, 0, 0); tx(8'hBE, 0, 0); tx(8'hEF, 1, 0);
    idle(3);
    chk("t4.lone_err", lone_err, 1); chk("t4.hv", hv_cnt, 0); chk("t4.out", outq.size(), 0);
    chk("t4.dst_hold", udp_dst_port, 16'd5000);
    clr(); frame1();
    chk("t4b.out", outq.size(), 4); chk("t4b.hv", hv_cnt, 1);

    // 5: truncated payload, then L<8
    clr(); hdr(16'd5000, 16'd20, 0);
    tx(8'h01, 0, 0); tx(8'h02, 0, 0); tx(8'h03, 0, 0); tx(8'h04, 0, 0); tx(8'h05, 1, 0);
    idle(3);
    exq = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h305};
    cmp_out("t5"); chk("t5.len", udp_len, 20);
    clr(); hdr(16'd5000, 16'd6, 0);
    tx(8'h11, 0, 0); tx(8'h22, 0, 0); tx(8'h33, 1, 0);
    idle(3);
    chk("t5b.lone_err", lone_err, 1); chk("t5b.hv", hv_cnt, 0); chk("t5b.out", outq.size(), 0);

    // 6: empty datagram ending on byte 7, then standalone error mid-payload
    clr(); hdr(16'd5000, 16'd8, 1);
    idle(3);
    chk("t6.hv", hv_cnt, 1); chk("t6.lone_eof", lone_eof, 1); chk("t6.lone_err", lone_err, 0);
    chk("t6.out", outq.size(), 0); chk("t6.len", udp_len, 8);
    clr(); hdr(16'd5000, 16'd12, 0);
    tx(8'hDE, 0, 0); tx(8'hAD, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_eof = 1'b0; in_err = 1'b1;
    idle(3);
    exq = '{10'h0DE, 10'h0AD};
    cmp_out("t6b"); chk("t6b.lone_eof", lone_eof, 1); chk("t6b.lone_err", lone_err, 1);

    // runt header
    clr(); tx(8'h12, 0, 0); tx(8'h34, 0, 0); tx(8'h13, 1, 0);
    idle(3);
    chk("runt.lone_err", lone_err, 1); chk("runt.hv", hv_cnt, 0);
    clr(); frame1();
    chk("runt.next", outq.size(), 4);

    // mid-frame reset
    clr(); tx(8'h12, 0, 0); tx(8'h34, 0, 0); tx(8'h13, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.len", udp_len, 0); chk("mrst.valid", out_valid, 0);
    idle(1);
    rst_n = 1'b1;
    clr(); frame1();
    exq = '{10'h0DE, 10'h0AD, 10'h0BE, 10'h2EF};
    cmp_out("mrst.next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
